wdt_sleep_ctrl: RTL

Watchdog-timer and power-down sequencer for the PIC16C5x core. It owns the WDT base counter, the 8-bit prescaler and the OPTION PSA/PS fields. It consumes the one-cycle execute pulses for CLRWDT, SLEEP and OPTION from the control unit. It stalls the fetch/execute sequencer while asleep or waking, and drives the TO/PD status bits and the WDT reset request.

---
 rtl/wdt_sleep_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wdt_sleep_ctrl.sv
// Watchdog timer, prescaler and SLEEP/WAKE sequencer for the PIC16C5x core.
// Drives core stall, TO/PD status and the WDT reset request.
module wdt_sleep_ctrl #(
  parameter int unsigned WDT_BASE    = 256,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wdt_en_i,
  input  logic       exec_clrwdt_i,
  input  logic       exec_sleep_i,
  input  logic       option_wr_i,
  input  logic       option_psa_i,
  input  logic [2:0] option_ps_i,
  input  logic       wake_in_i,
  output logic       core_hold_o,
  output logic       wdt_reset_o,
  output logic       to_n_o,
  output logic       pd_n_o,
  output logic [1:0] ctrl_state_o
);

  localparam int unsigned CW = (WDT_BASE > 1) ? $clog2(WDT_BASE) : 1;
  localparam int unsigned WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WDT_BASE - 1);
  localparam logic [WW-1:0] WK_MAX  = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SLEEP = 2'b01,
    ST_WAKE  = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    pre_q, pre_d;
  logic [WW-1:0] wk_q, wk_d;
  logic          psa_q, psa_d;
  logic [2:0]    ps_q, ps_d;
  logic          to_n_q, to_n_d;
  logic          pd_n_q, pd_n_d;
  logic          wrst_q, wrst_d;
  logic          hold_q, hold_d;

  logic       tick;
  logic       pre_hit;
  logic       timeout;
  logic [7:0] pre_mask;

  always_comb begin
    tick     = wdt_en_i && (cnt_q == CNT_MAX);
    // prescaler terminal count is 2^ps - 1
    pre_mask = 8'hFF >> (4'd8 - {1'b0, ps_q});
    pre_hit  = (pre_q == pre_mask);
    timeout  = tick && (!psa_q || pre_hit) && !exec_clrwdt_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = wdt_en_i ? (tick ? '0 : cnt_q + 1'b1) : '0;
    pre_d   = pre_q;
    wk_d    = wk_q;
    psa_d   = psa_q;
    ps_d    = ps_q;
    to_n_d  = to_n_q;
    pd_n_d  = pd_n_q;
    wrst_d  = 1'b0;
    if (tick && psa_q) begin
      pre_d = pre_hit ? 8'd0 : pre_q + 8'd1;
    end
    case (state_q)
      ST_RUN: begin
        if (exec_sleep_i && !exec_clrwdt_i) begin
          state_d = ST_SLEEP;
          cnt_d   = '0;
          pre_d   = '0;
          to_n_d  = 1'b1;
          pd_n_d  = 1'b0;
        end else if (timeout) begin
          wrst_d = 1'b1;
          to_n_d = 1'b0;
        end
      end
      ST_SLEEP: begin
        if (timeout) to_n_d = 1'b0;
        if (timeout || wake_in_i) begin
          state_d = ST_WAKE;
          wk_d    = '0;
        end
      end
      ST_WAKE: begin
        if (timeout) to_n_d = 1'b0;
        if (wk_q == WK_MAX) begin
          state_d = ST_RUN;
          wk_d    = '0;
        end else begin
          wk_d = wk_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        wk_d    = '0;
      end
    endcase
    if (timeout) begin
      cnt_d = '0;
      pre_d = '0;
    end
    if (option_wr_i) begin
      psa_d = option_psa_i;
      ps_d  = option_ps_i;
      pre_d = '0;
    end
    if (exec_clrwdt_i) begin
      cnt_d  = '0;
      pre_d  = '0;
      to_n_d = 1'b1;
      pd_n_d = 1'b1;
    end
    hold_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pre_q   <= '0;
      wk_q    <= '0;
      psa_q   <= 1'b1;
      ps_q    <= 3'b111;
      to_n_q  <= 1'b1;
      pd_n_q  <= 1'b1;
      wrst_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      wk_q    <= wk_d;
      psa_q   <= psa_d;
      ps_q    <= ps_d;
      to_n_q  <= to_n_d;
      pd_n_q  <= pd_n_d;
      wrst_q  <= wrst_d;
      hold_q  <= hold_d;
    end
  end

  assign core_hold_o  = hold_q;
  assign wdt_reset_o  = wrst_q;
  assign to_n_o       = to_n_q;
  assign pd_n_o       = pd_n_q;
  assign ctrl_state_o = state_q;

endmodule
